// File: rtl/serial_add_unit.sv
// serial_add_unit
//   Bit-serial add/subtract engine. Latches two WIDTH-bit operands on an
//   accepted start and pushes one bit pair per clock, LSB first, through a
//   single full-adder cell. The carry lives in a flop between cycles, and the
//   sum bits collect in a shift register. The result, carry-out and signed
//   overflow are published together with a one-cycle done pulse.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, sampled only while idle
//   a, b   in   operands, sampled on the accepting edge
//   cin    in   carry-in for add (ignored when sub=1)
//   sub    in   1 = compute a-b
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the final bit of the next operation
//   cout   out  final carry out (for sub: 1 = no borrow)
//   ovf    out  signed overflow of the effective addition
module serial_add_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_IN   = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             cmsb;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_next;

  // The single full-adder cell, fed by the LSBs of the operand shifters.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c    = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    sum_next = {bit_s, sum_sh[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_c;
          cnt    <= cnt + 1'b1;
          // Carry into the MSB, needed to form signed overflow at the end.
          if (cnt == MSB_IN) cmsb <= bit_c;
          if (cnt == LAST_BIT) begin
            sum   <= sum_next;
            cout  <= bit_c;
            ovf   <= cmsb ^ bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
